// File: rtl/mul_pkg.sv
// Shared types and sizing for the shift-and-add multiplier controller.
package mul_pkg;

  localparam int W     = 16;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1), which fits unsigned.
  function automatic logic [W-1:0] magW(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Request/result handshake bundle between the execute stage (master) and the multiplier (slave).
interface shift_add_mul_ctrl_if;
  import mul_pkg::*;

  logic             start_valid;
  logic             start_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res;
  logic             busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, res, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, res, busy
  );

endinterface

// File: rtl/adder_w.sv
// W-bit combinational ripple-carry adder, carry-in fixed at zero.
module adder_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_carry = w_c[W];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential shift-and-add multiplier: one adder pass per cycle, W passes per product.
// Define MUL_SIGNED_EN for two's complement operands (adds a one-cycle sign FIX state).
module shift_add_mul_ctrl
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_add_mul_ctrl_if.slave bus
);

  mul_state_t       r_state;
  logic [W-1:0]     r_mcand;
  // Top bit of the (2W+1)-bit P is always zero after the shift, so only 2W bits are kept.
  logic [2*W-1:0]   r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_res;
  logic             r_res_valid;
  logic             r_start_ready;
  logic             r_busy;
`ifdef MUL_SIGNED_EN
  logic             r_neg;
`endif

  logic [W-1:0]     w_addend;
  logic [W-1:0]     w_sum;
  logic             w_carry;
  logic [2*W-1:0]   w_p_next;

  assign w_addend = r_p[0] ? r_mcand : '0;

  adder_w #(.W(W)) u_adder (
    .i_a     (r_p[2*W-1:W]),
    .i_b     (w_addend),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_p_next = {w_carry, w_sum, r_p[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mcand       <= '0;
      r_p           <= '0;
      r_cnt         <= '0;
      r_res         <= '0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b0;
      r_busy        <= 1'b0;
`ifdef MUL_SIGNED_EN
      r_neg         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid && r_start_ready) begin
`ifdef MUL_SIGNED_EN
            r_mcand <= magW(bus.a);
            r_p     <= {{W{1'b0}}, magW(bus.b)};
            r_neg   <= bus.a[W-1] ^ bus.b[W-1];
`else
            r_mcand <= bus.a;
            r_p     <= {{W{1'b0}}, bus.b};
`endif
            r_cnt         <= CNT_W'(W-1);
            r_state       <= RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end else begin
            r_start_ready <= 1'b1;
          end
        end
        RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
`ifdef MUL_SIGNED_EN
            r_state     <= FIX;
`else
            r_state     <= DONE;
            r_res       <= w_p_next;
            r_res_valid <= 1'b1;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        FIX: begin
          r_res       <= r_neg ? (~r_p + 1'b1) : r_p;
          r_res_valid <= 1'b1;
          r_state     <= DONE;
        end
`endif
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res         = r_res;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench for shift_add_mul_ctrl with an arithmetic reference model and per-cycle compare.
// Honours MUL_SIGNED_EN the same way as the design (signed operands, one extra cycle latency).
module tb_shift_add_mul_ctrl;

  localparam int W = 16;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nErrors;

  shift_add_mul_ctrl_if bus ();

  shift_add_mul_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a countdown to the exact product, computed with plain arithmetic.
  logic        mReady;
  logic        mBusy;
  logic        mValid;
  logic [31:0] mRes;
  logic [31:0] mProd;
  int          mLeft;

  function automatic logic [31:0] product(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL_SIGNED_EN
    logic signed [31:0] sx, sy;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    return sx * sy;
`else
    return {16'd0, x} * {16'd0, y};
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mReady <= 1'b0;
      mBusy  <= 1'b0;
      mValid <= 1'b0;
      mRes   <= '0;
      mProd  <= '0;
      mLeft  <= 0;
    end else if (mValid && bus.res_ready) begin
      mValid <= 1'b0;
      mBusy  <= 1'b0;
      mReady <= 1'b1;
    end else if (mLeft != 0) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin
        mValid <= 1'b1;
        mRes   <= mProd;
      end
    end else if (!mBusy) begin
      if (mReady && bus.start_valid) begin
        mBusy  <= 1'b1;
        mReady <= 1'b0;
        mLeft  <= LAT;
        mProd  <= product(bus.a, bus.b);
      end else begin
        mReady <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cmp_start_ready", {31'd0, bus.start_ready}, {31'd0, mReady});
    checkOutput("cmp_res_valid",   {31'd0, bus.res_valid},   {31'd0, mValid});
    checkOutput("cmp_busy",        {31'd0, bus.busy},        {31'd0, mBusy});
    if (mValid || !rst_n)
      checkOutput("cmp_res", bus.res, mRes);
  end

  // One operation: wait for ready, issue, measure latency, hold res_ready low, handshake.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input int holdCycles, input bit tieReady,
                               input logic [31:0] expRes);
    int n;
    n = 0;
    while (!bus.start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("wait_start_ready_timeout", 32'd0, 32'd1);
    bus.res_ready   = tieReady;
    bus.start_valid = 1'b1;
    bus.a           = av;
    bus.b           = bv;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a           = 16'($urandom);
    bus.b           = 16'($urandom);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", n, LAT);
    checkOutput("res_literal", bus.res, expRes);
    if (!tieReady) begin
      for (int i = 0; i < holdCycles; i++) begin
        bus.start_valid = 1'b1;
        bus.a           = 16'h1111;
        bus.b           = 16'h2222;
        @(posedge clk); #1;
        checkOutput("res_held", bus.res, expRes);
        checkOutput("start_blocked", {31'd0, bus.start_ready}, 32'd0);
      end
      bus.start_valid = 1'b0;
      bus.res_ready   = 1'b1;
    end
    @(posedge clk); #1;
    bus.res_ready = tieReady;
    checkOutput("post_hs_busy",        {31'd0, bus.busy},        32'd0);
    checkOutput("post_hs_res_valid",   {31'd0, bus.res_valid},   32'd0);
    checkOutput("post_hs_start_ready", {31'd0, bus.start_ready}, 32'd1);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    nChecks         = 0;
    nErrors         = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    #1;
    checkOutput("rst_start_ready", {31'd0, bus.start_ready}, 32'd0);
    checkOutput("rst_res_valid",   {31'd0, bus.res_valid},   32'd0);
    checkOutput("rst_res",         bus.res,                  32'd0);
    checkOutput("rst_busy",        {31'd0, bus.busy},        32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_start_ready", {31'd0, bus.start_ready}, 32'd1);

    applyStimulus(16'd0,      16'd0,      0, 1'b0, 32'h0000_0000);
    applyStimulus(16'd10,     16'd5,      0, 1'b1, 32'd50);
`ifdef MUL_SIGNED_EN
    applyStimulus(16'hFFFF,   16'hFFFF,   0, 1'b0, 32'h0000_0001);
    applyStimulus(16'hAAAA,   16'h5555,   5, 1'b0, 32'hE38E_1C72);
    applyStimulus(16'hFFFD,   16'd5,      0, 1'b0, 32'hFFFF_FFF1);
`else
    applyStimulus(16'hFFFF,   16'hFFFF,   0, 1'b0, 32'hFFFE_0001);
    applyStimulus(16'hAAAA,   16'h5555,   5, 1'b0, 32'h38E3_1C72);
    applyStimulus(16'hFFFD,   16'd5,      0, 1'b0, 32'h0004_FFF1);
`endif
    applyStimulus(16'h8000,   16'h8000,   2, 1'b0, 32'h4000_0000);

    // Reset during RUN: outputs clear at once, then a fresh operation works.
    bus.start_valid = 1'b1;
    bus.a           = 16'd1234;
    bus.b           = 16'd567;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_start_ready", {31'd0, bus.start_ready}, 32'd0);
    checkOutput("midrst_res_valid",   {31'd0, bus.res_valid},   32'd0);
    checkOutput("midrst_res",         bus.res,                  32'd0);
    checkOutput("midrst_busy",        {31'd0, bus.busy},        32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'd3, 16'd7, 0, 1'b0, 32'd21);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
